// File: rtl/uart_rx_engine_if.sv
// Receive-side word handshake between the UART receiver and its consumer.
// master = receiver (drives word and flags), slave = consumer (drives rx_ready).
interface uart_rx_engine_if #(
  parameter int DATA_BITS = 8
) ();
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 rx_ready;
  logic                 parity_err;
  logic                 frame_err;
  logic                 overrun;

  modport master (
    output rx_data, rx_valid, parity_err, frame_err, overrun,
    input  rx_ready
  );

  modport slave (
    input  rx_data, rx_valid, parity_err, frame_err, overrun,
    output rx_ready
  );
endinterface

// File: rtl/uart_rx_engine.sv
// UART receiver: 2-flop line synchroniser, mid-bit sampling of 5..9 data bits,
// optional parity, 1 or 2 stop bits; words delivered on a valid/ready handshake.
module uart_rx_engine #(
  parameter int CLKS_PER_BIT = 434,
  parameter int DATA_BITS    = 8,
  parameter int PARITY_MODE  = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             rx,
  output logic             busy,
  uart_rx_engine_if.master rx_if
);

  localparam int            TW     = $clog2(CLKS_PER_BIT);
  localparam logic [TW-1:0] T_HALF = TW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TW-1:0] T_LAST = TW'(CLKS_PER_BIT - 1);
  localparam logic [3:0]    B_LAST = 4'(DATA_BITS - 1);
  localparam logic [3:0]    P_LAST = 4'(STOP_BITS - 1);

  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
    $error("uart_rx_engine: DATA_BITS must be in 5..9");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
    $error("uart_rx_engine: STOP_BITS must be 1 or 2");
  end
  if (CLKS_PER_BIT < 4) begin : g_bad_clks_per_bit
    $error("uart_rx_engine: CLKS_PER_BIT must be at least 4");
  end

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK
  } state_t;

  state_t                state_reg;
  logic [1:0]            sync_reg;
  logic [TW-1:0]         tcnt_reg;
  logic [3:0]            bcnt_reg;
  logic [DATA_BITS-1:0]  shift_reg;
  logic                  perr_reg;
  logic                  ferr_reg;
  logic                  commit_reg;
  logic                  busy_reg;

  logic [DATA_BITS-1:0]  data_reg;
  logic                  valid_reg;
  logic                  parity_err_reg;
  logic                  frame_err_reg;
  logic                  overrun_reg;

  logic                  rx_s;

  assign rx_s = sync_reg[1];

  // The line is idle high, so the synchroniser resets to 1 to avoid a false start.
  always_ff @(posedge clk) begin
    if (!reset) begin
      sync_reg <= 2'b11;
    end else begin
      sync_reg <= {sync_reg[0], rx};
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg  <= S_IDLE;
      tcnt_reg   <= '0;
      bcnt_reg   <= '0;
      shift_reg  <= '0;
      perr_reg   <= 1'b0;
      ferr_reg   <= 1'b0;
      commit_reg <= 1'b0;
      busy_reg   <= 1'b0;
    end else begin
      commit_reg <= 1'b0;
      case (state_reg)
        S_IDLE: begin
          tcnt_reg <= '0;
          if (!rx_s) begin
            state_reg <= S_START;
            busy_reg  <= 1'b1;
          end
        end
        S_START: begin
          if (tcnt_reg == T_HALF) begin
            tcnt_reg <= '0;
            bcnt_reg <= '0;
            if (rx_s) begin
              state_reg <= S_IDLE;
              busy_reg  <= 1'b0;
            end else begin
              state_reg <= S_DATA;
              perr_reg  <= 1'b0;
              ferr_reg  <= 1'b0;
            end
          end else begin
            tcnt_reg <= tcnt_reg + 1'b1;
          end
        end
        S_DATA: begin
          if (tcnt_reg == T_LAST) begin
            tcnt_reg  <= '0;
            shift_reg <= {rx_s, shift_reg[DATA_BITS-1:1]};
            if (bcnt_reg == B_LAST) begin
              bcnt_reg  <= '0;
              state_reg <= (PARITY_MODE != 0) ? S_PARITY : S_STOP;
            end else begin
              bcnt_reg <= bcnt_reg + 1'b1;
            end
          end else begin
            tcnt_reg <= tcnt_reg + 1'b1;
          end
        end
        S_PARITY: begin
          if (tcnt_reg == T_LAST) begin
            tcnt_reg  <= '0;
            perr_reg  <= ((^shift_reg) ^ rx_s) != (PARITY_MODE == 2);
            state_reg <= S_STOP;
          end else begin
            tcnt_reg <= tcnt_reg + 1'b1;
          end
        end
        S_STOP: begin
          if (tcnt_reg == T_LAST) begin
            tcnt_reg <= '0;
            if (!rx_s) ferr_reg <= 1'b1;
            if (bcnt_reg == P_LAST) begin
              // Leaving at mid-stop lets a back-to-back start edge be caught on time.
              bcnt_reg   <= '0;
              commit_reg <= 1'b1;
              if (!rx_s) begin
                state_reg <= S_BREAK;
              end else begin
                state_reg <= S_IDLE;
                busy_reg  <= 1'b0;
              end
            end else begin
              bcnt_reg <= bcnt_reg + 1'b1;
            end
          end else begin
            tcnt_reg <= tcnt_reg + 1'b1;
          end
        end
        S_BREAK: begin
          if (rx_s) begin
            state_reg <= S_IDLE;
            busy_reg  <= 1'b0;
          end
        end
        default: begin
          state_reg <= S_IDLE;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  // A commit always wins over the handshake clear, so a word is never lost silently.
  always_ff @(posedge clk) begin
    if (!reset) begin
      data_reg       <= '0;
      valid_reg      <= 1'b0;
      parity_err_reg <= 1'b0;
      frame_err_reg  <= 1'b0;
      overrun_reg    <= 1'b0;
    end else begin
      overrun_reg <= 1'b0;
      if (commit_reg) begin
        data_reg       <= shift_reg;
        parity_err_reg <= perr_reg;
        frame_err_reg  <= ferr_reg;
        valid_reg      <= 1'b1;
        overrun_reg    <= valid_reg && !rx_if.rx_ready;
      end else if (valid_reg && rx_if.rx_ready) begin
        valid_reg <= 1'b0;
      end
    end
  end

  assign rx_if.rx_data    = data_reg;
  assign rx_if.rx_valid   = valid_reg;
  assign rx_if.parity_err = parity_err_reg;
  assign rx_if.frame_err  = frame_err_reg;
  assign rx_if.overrun    = overrun_reg;
  assign busy             = busy_reg;

endmodule

// File: tb/tb_uart_rx_engine.sv
// Bench for uart_rx_engine: four instances (8N1, 8E1, 8O1, 9N2) at 16 clocks per bit,
// directed scenarios plus random frames checked against a frame-level model.
module tb_uart_rx_engine;
  localparam int CPB = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset = 1'b0;
  logic rx_l [4] = '{1'b1, 1'b1, 1'b1, 1'b1};
  logic rdy  [4] = '{1'b1, 1'b1, 1'b1, 1'b1};

  logic [8:0] dat [4];
  logic       val [4];
  logic       pe  [4];
  logic       fe  [4];
  logic       ov  [4];
  logic       bs  [4];

  // Frame format of each instance.
  int mode_of  [4] = '{0, 1, 2, 0};
  int nbits_of [4] = '{8, 8, 8, 9};
  int nstop_of [4] = '{1, 1, 1, 2};

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_assert = 0;
  int n_fail   = 0;

  uart_rx_engine_if #(.DATA_BITS(8)) if0 ();
  uart_rx_engine_if #(.DATA_BITS(8)) if1 ();
  uart_rx_engine_if #(.DATA_BITS(8)) if2 ();
  uart_rx_engine_if #(.DATA_BITS(9)) if3 ();

  uart_rx_engine #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_MODE(0), .STOP_BITS(1)) u0 (
    .clk(clk), .reset(reset), .rx(rx_l[0]), .busy(bs[0]), .rx_if(if0));
  uart_rx_engine #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_MODE(1), .STOP_BITS(1)) u1 (
    .clk(clk), .reset(reset), .rx(rx_l[1]), .busy(bs[1]), .rx_if(if1));
  uart_rx_engine #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_MODE(2), .STOP_BITS(1)) u2 (
    .clk(clk), .reset(reset), .rx(rx_l[2]), .busy(bs[2]), .rx_if(if2));
  uart_rx_engine #(.CLKS_PER_BIT(CPB), .DATA_BITS(9), .PARITY_MODE(0), .STOP_BITS(2)) u3 (
    .clk(clk), .reset(reset), .rx(rx_l[3]), .busy(bs[3]), .rx_if(if3));

  assign if0.rx_ready = rdy[0];
  assign if1.rx_ready = rdy[1];
  assign if2.rx_ready = rdy[2];
  assign if3.rx_ready = rdy[3];

  assign dat[0] = {1'b0, if0.rx_data};
  assign dat[1] = {1'b0, if1.rx_data};
  assign dat[2] = {1'b0, if2.rx_data};
  assign dat[3] = if3.rx_data;
  assign val[0] = if0.rx_valid;   assign pe[0] = if0.parity_err;
  assign val[1] = if1.rx_valid;   assign pe[1] = if1.parity_err;
  assign val[2] = if2.rx_valid;   assign pe[2] = if2.parity_err;
  assign val[3] = if3.rx_valid;   assign pe[3] = if3.parity_err;
  assign fe[0]  = if0.frame_err;  assign ov[0] = if0.overrun;
  assign fe[1]  = if1.frame_err;  assign ov[1] = if1.overrun;
  assign fe[2]  = if2.frame_err;  assign ov[2] = if2.overrun;
  assign fe[3]  = if3.frame_err;  assign ov[3] = if3.overrun;

  // Word monitor: a new word shows up as a valid rise or an overrun overwrite.
  typedef struct {
    int         d;
    logic [8:0] data;
    logic       pe;
    logic       fe;
    int         cyc;
  } ev_t;

  ev_t        ev_q [$];
  logic [3:0] val_prev = '0;
  int         ov_cnt [4] = '{0, 0, 0, 0};

  always @(negedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if ((val[i] && !val_prev[i]) || ov[i]) begin
        ev_t tmp;
        tmp.d    = i;
        tmp.data = dat[i];
        tmp.pe   = pe[i];
        tmp.fe   = fe[i];
        tmp.cyc  = cyc;
        ev_q.push_back(tmp);
      end
      if (ov[i]) ov_cnt[i]++;
      val_prev[i] = val[i];
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int count_q(input int d);
    int n = 0;
    foreach (ev_q[j]) if (ev_q[j].d == d) n++;
    return n;
  endfunction

  // Reference: parity error means the received ones count disagrees with the mode.
  function automatic logic exp_perr(input int mode, input logic [8:0] data,
                                    input int nbits, input int pbit);
    int ones = pbit;
    for (int i = 0; i < nbits; i++) ones += int'(data[i]);
    if (mode == 1) return (ones % 2) == 1;
    if (mode == 2) return (ones % 2) == 0;
    return 1'b0;
  endfunction

  // Latency counts from the first clock edge that sees rx low (t_fall + 1).
  function automatic int exp_cycle(input int t_fall, input int nbits, input int p, input int nstop);
    return t_fall + 1 + 2 + CPB / 2 + (nbits + p + nstop) * CPB + 1;
  endfunction

  task automatic drive_bit(input int d, input logic v);
    rx_l[d] = v;
    repeat (CPB) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input int d, input logic [8:0] data, input int pbit,
                            input logic stop_val, input bit hold_low, output int t_fall);
    @(posedge clk);
    #1;
    t_fall = cyc;
    drive_bit(d, 1'b0);
    for (int i = 0; i < nbits_of[d]; i++) drive_bit(d, data[i]);
    if (mode_of[d] != 0) drive_bit(d, pbit[0]);
    for (int i = 0; i < nstop_of[d]; i++) drive_bit(d, stop_val);
    if (!hold_low) rx_l[d] = 1'b1;
  endtask

  task automatic pop_word(input int d, input string tag, output ev_t e);
    bit ok = 1'b0;
    e.d = d; e.data = '0; e.pe = 1'b0; e.fe = 1'b0; e.cyc = 0;
    for (int k = 0; k < 3000 && !ok; k++) begin
      int idx = -1;
      for (int j = 0; j < ev_q.size(); j++) if (idx < 0 && ev_q[j].d == d) idx = j;
      if (idx >= 0) begin
        e = ev_q[idx];
        ev_q.delete(idx);
        ok = 1'b1;
      end else begin
        @(posedge clk);
        #1;
      end
    end
    check({tag, "_arrived"}, 32'(ok), 32'd1);
  endtask

  task automatic frame_check(input int d, input logic [8:0] data, input int pbit,
                             input logic stop_val, input string tag);
    int  t;
    ev_t e;
    send_frame(d, data, pbit, stop_val, 1'b0, t);
    pop_word(d, tag, e);
    $display("rx d%0d %s: data=%0h perr=%0b ferr=%0b at cycle %0d", d, tag, e.data, e.pe, e.fe, e.cyc);
    check({tag, "_data"}, 32'(e.data), 32'(data));
    check({tag, "_perr"}, 32'(e.pe), 32'(exp_perr(mode_of[d], data, nbits_of[d], pbit)));
    check({tag, "_ferr"}, 32'(e.fe), 32'(!stop_val));
    check({tag, "_latency"}, 32'(e.cyc),
          32'(exp_cycle(t, nbits_of[d], (mode_of[d] != 0) ? 1 : 0, nstop_of[d])));
    repeat (2 * CPB) @(posedge clk);
    #1;
  endtask

  initial begin
    int  t;
    int  ov0;
    ev_t e;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_data",  32'(dat[0]), 32'd0);
    check("rst_valid", 32'(val[0]), 32'd0);
    check("rst_perr",  32'(pe[1]),  32'd0);
    check("rst_ferr",  32'(fe[0]),  32'd0);
    check("rst_ovr",   32'(ov[0]),  32'd0);
    check("rst_busy",  32'(bs[0]),  32'd0);
    reset = 1'b1;
    repeat (4) @(posedge clk);
    #1;

    // 8N1 0xA5, single valid pulse
    frame_check(0, 9'h0A5, 0, 1'b1, "t1_a5");
    check("t1_valid_cleared", 32'(val[0]), 32'd0);
    check("t1_single_word", 32'(count_q(0)), 32'd0);

    // Start-bit glitch
    @(posedge clk);
    #1;
    rx_l[0] = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("t2_busy_in_start", 32'(bs[0]), 32'd1);
    rx_l[0] = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    check("t2_busy_idle", 32'(bs[0]), 32'd0);
    check("t2_no_word", 32'(count_q(0)), 32'd0);
    check("t2_valid", 32'(val[0]), 32'd0);

    // Parity, even then odd
    frame_check(1, 9'h00F, 1, 1'b1, "t3_even_p1");
    frame_check(1, 9'h00F, 0, 1'b1, "t3_even_p0");
    frame_check(2, 9'h00F, 1, 1'b1, "t3_odd_p1");
    frame_check(2, 9'h00F, 0, 1'b1, "t3_odd_p0");

    // Framing error followed by a held-low break
    send_frame(0, 9'h03C, 0, 1'b0, 1'b1, t);
    pop_word(0, "t4_break", e);
    $display("rx d0 t4_break: data=%0h perr=%0b ferr=%0b", e.data, e.pe, e.fe);
    check("t4_data", 32'(e.data), 32'h3C);
    check("t4_ferr", 32'(e.fe), 32'd1);
    repeat (40 * CPB) @(posedge clk);
    #1;
    check("t4_busy_in_break", 32'(bs[0]), 32'd1);
    check("t4_one_word", 32'(count_q(0)), 32'd0);
    rx_l[0] = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("t4_busy_released", 32'(bs[0]), 32'd0);
    frame_check(0, 9'h055, 0, 1'b1, "t4_clean");

    // Overrun with rx_ready low
    rdy[0] = 1'b0;
    ov0 = ov_cnt[0];
    send_frame(0, 9'h011, 0, 1'b1, 1'b0, t);
    repeat (CPB) @(posedge clk);
    #1;
    send_frame(0, 9'h022, 0, 1'b1, 1'b0, t);
    pop_word(0, "t5_first", e);
    $display("rx d0 t5_first: data=%0h", e.data);
    check("t5_first_data", 32'(e.data), 32'h11);
    pop_word(0, "t5_second", e);
    $display("rx d0 t5_second: data=%0h", e.data);
    check("t5_second_data", 32'(e.data), 32'h22);
    check("t5_overrun_cycles", 32'(ov_cnt[0] - ov0), 32'd1);
    check("t5_held_valid", 32'(val[0]), 32'd1);
    check("t5_held_data", 32'(dat[0]), 32'h22);
    rdy[0] = 1'b1;
    @(posedge clk);
    #1;
    check("t5_valid_falls", 32'(val[0]), 32'd0);

    // Reset mid-DATA of 0x77
    @(posedge clk);
    #1;
    drive_bit(0, 1'b0);
    for (int i = 0; i < 3; i++) drive_bit(0, 1'b1);
    check("t6_busy_mid", 32'(bs[0]), 32'd1);
    reset = 1'b0;
    rx_l[0] = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b1;
    check("t6_rst_data",  32'(dat[0]), 32'd0);
    check("t6_rst_valid", 32'(val[0]), 32'd0);
    check("t6_rst_busy",  32'(bs[0]),  32'd0);
    check("t6_rst_ferr",  32'(fe[0]),  32'd0);
    repeat (12 * CPB) @(posedge clk);
    #1;
    check("t6_no_word", 32'(count_q(0)), 32'd0);
    frame_check(0, 9'h081, 0, 1'b1, "t6_after");

    // 9 data bits, 2 stop bits
    frame_check(3, 9'h1FF, 0, 1'b1, "t6_9n2_1ff");
    frame_check(3, 9'h0A6, 0, 1'b1, "t6_9n2_0a6");

    // Random frames across formats
    for (int k = 0; k < 24; k++) begin
      int         d;
      int         pbit;
      logic [8:0] data;
      logic       stop_val;
      d        = k % 4;
      data     = 9'($urandom_range(0, (1 << nbits_of[d]) - 1));
      pbit     = (mode_of[d] != 0) ? int'($urandom_range(0, 1)) : 0;
      stop_val = !(d == 0 && $urandom_range(0, 3) == 0);
      frame_check(d, data, pbit, stop_val, "rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
